pipeline_stall_controller: RTL and testbench

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

---
 rtl/pipeline_stall_controller.sv | 140 ++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall controller: load-use and branch-use interlocks, memory-wait
// freeze, stall statistics and a sticky memory-wait timeout flag.
module pipeline_stall_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        loadUseEX_i,
  input  logic        branchUseID_i,
  input  logic        loadHazard_i,
  input  logic        branchTakenID_i,
  input  logic        jumpID_i,
  input  logic        dmemReq_i,
  input  logic        dmemReady_i,
  input  logic        clearStats_i,
  output logic        pcWrite_o,
  output logic        ifidWrite_o,
  output logic        ifidFlush_o,
  output logic        idexBubble_o,
  output logic        pipeHold_o,
  output logic        loadStallFlag_o,
  output logic [15:0] stallCount_o,
  output logic        memTimeout_o,
  output logic [1:0]  state_o
);

  localparam int unsigned CountWidth = 16;
  localparam int unsigned HoldWidth  = 8;

  typedef enum logic [1:0] {
    Run     = 2'd0,
    LStall1 = 2'd1,
    LStall2 = 2'd2
  } stateT;

  stateT                 stateQ;
  stateT                 stateD;
  logic                  stallC;
  logic                  flushC;
  logic [HoldWidth-1:0]  holdCount;

  // Memory wait freezes the whole pipeline regardless of FSM state
  assign pipeHold_o = dmemReq_i & ~dmemReady_i;
  assign state_o    = stateQ;

  // Stall decision and next state; a hold freezes the current state
  always_comb begin
    stallC = 1'b0;
    flushC = 1'b0;
    stateD = stateQ;
    case (stateQ)
      Run: begin
        if (!pipeHold_o) begin
          if (branchUseID_i) begin
            stallC = 1'b1;
            stateD = LStall1;
          end else if (loadUseEX_i) begin
            stallC = 1'b1;
            stateD = LStall2;
          end else begin
            flushC = branchTakenID_i | jumpID_i;
          end
        end
      end
      LStall1: begin
        if (!pipeHold_o) begin
          stallC = 1'b1;
          stateD = LStall2;
        end
      end
      LStall2: begin
        if (!pipeHold_o) begin
          stallC = loadHazard_i;
          stateD = Run;
        end
      end
      default: stateD = Run;
    endcase
  end

  // Pipeline control outputs; reset forces a bubble with the PC frozen
  always_comb begin
    pcWrite_o       = 1'b0;
    ifidWrite_o     = 1'b0;
    ifidFlush_o     = 1'b0;
    idexBubble_o    = 1'b0;
    loadStallFlag_o = 1'b0;
    if (!rst_n) begin
      idexBubble_o = 1'b1;
    end else begin
      loadStallFlag_o = (stateQ == LStall2);
      if (!pipeHold_o) begin
        if (stallC) begin
          idexBubble_o = 1'b1;
        end else begin
          pcWrite_o   = 1'b1;
          ifidWrite_o = 1'b1;
          ifidFlush_o = flushC;
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= Run;
    end else begin
      stateQ <= stateD;
    end
  end

  // Consecutive hold-cycle counter, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdCount <= '0;
    end else if (!pipeHold_o) begin
      holdCount <= '0;
    end else if (holdCount != '1) begin
      holdCount <= holdCount + HoldWidth'(1);
    end
  end

  // Stall statistics and sticky timeout; clear takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCount_o <= '0;
      memTimeout_o <= 1'b0;
    end else if (clearStats_i) begin
      stallCount_o <= '0;
      memTimeout_o <= 1'b0;
    end else begin
      if (stallC && (stallCount_o != '1)) begin
        stallCount_o <= stallCount_o + CountWidth'(1);
      end
      if (pipeHold_o && (holdCount == HoldWidth'(254))) begin
        memTimeout_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: a queue-based reference
// model predicts every cycle's outputs; a monitor compares at the falling edge.
module tb_pipeline_stall_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        loadUseEX_i, branchUseID_i, loadHazard_i, branchTakenID_i;
  logic        jumpID_i, dmemReq_i, dmemReady_i, clearStats_i;
  logic        pcWrite_o, ifidWrite_o, ifidFlush_o, idexBubble_o, pipeHold_o;
  logic        loadStallFlag_o, memTimeout_o;
  logic [15:0] stallCount_o;
  logic [1:0]  state_o;

  always #5 clk = ~clk;

  pipeline_stall_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .loadUseEX_i    (loadUseEX_i),
    .branchUseID_i  (branchUseID_i),
    .loadHazard_i   (loadHazard_i),
    .branchTakenID_i(branchTakenID_i),
    .jumpID_i       (jumpID_i),
    .dmemReq_i      (dmemReq_i),
    .dmemReady_i    (dmemReady_i),
    .clearStats_i   (clearStats_i),
    .pcWrite_o      (pcWrite_o),
    .ifidWrite_o    (ifidWrite_o),
    .ifidFlush_o    (ifidFlush_o),
    .idexBubble_o   (idexBubble_o),
    .pipeHold_o     (pipeHold_o),
    .loadStallFlag_o(loadStallFlag_o),
    .stallCount_o   (stallCount_o),
    .memTimeout_o   (memTimeout_o),
    .state_o        (state_o)
  );

  typedef struct packed {
    logic lu, bu, lh, bt, jp, req, rdy, clr;
  } stimT;

  typedef struct packed {
    logic        pcW, ifW, fl, bub, hold, lsf, mt;
    logic [1:0]  st;
    logic [15:0] sc;
  } expT;

  expT expQ[$];
  int  compared   = 0;
  int  mismatched = 0;

  // Reference model: pending interlock cycles as a queue of obligations.
  // 1 = unconditional stall cycle, 2 = stall only if the bypass still needs it.
  int  pending[$];
  int  stallsM   = 0;
  int  holdRun   = 0;
  bit  timeoutM  = 1'b0;

  task automatic predict(input logic r, input stimT s);
    expT  e;
    int   phase;
    logic hold, stall;
    hold   = s.req & ~s.rdy;
    e      = '0;
    e.hold = hold;
    if (!r) begin
      pending.delete();
      stallsM  = 0;
      holdRun  = 0;
      timeoutM = 1'b0;
      e.bub    = 1'b1;
      expQ.push_back(e);
      return;
    end
    phase = (pending.size() == 0) ? 0 : pending[0];
    stall = 1'b0;
    if (!hold) stall = (phase == 0) ? (s.bu | s.lu) : (phase == 1) ? 1'b1 : s.lh;
    e.lsf = (phase == 2);
    e.st  = 2'(phase);
    e.sc  = 16'(stallsM);
    e.mt  = timeoutM;
    if (!hold) begin
      if (stall) begin
        e.bub = 1'b1;
      end else begin
        e.pcW = 1'b1;
        e.ifW = 1'b1;
        e.fl  = (phase == 0) & (s.bt | s.jp);
      end
    end
    expQ.push_back(e);
    if (!hold) begin
      if (phase == 0) begin
        if (s.bu) begin
          pending.push_back(1);
          pending.push_back(2);
        end else if (s.lu) begin
          pending.push_back(2);
        end
      end else begin
        void'(pending.pop_front());
      end
    end
    holdRun = hold ? holdRun + 1 : 0;
    if (s.clr) begin
      stallsM  = 0;
      timeoutM = 1'b0;
    end else begin
      if (stall && stallsM < 65535) stallsM = stallsM + 1;
      if (holdRun == 255) timeoutM = 1'b1;
    end
  endtask

  task automatic step(input logic r, input stimT s);
    @(posedge clk);
    #1;
    rst_n           = r;
    loadUseEX_i     = s.lu;
    branchUseID_i   = s.bu;
    loadHazard_i    = s.lh;
    branchTakenID_i = s.bt;
    jumpID_i        = s.jp;
    dmemReq_i       = s.req;
    dmemReady_i     = s.rdy;
    clearStats_i    = s.clr;
    predict(r, s);
  endtask

  function automatic stimT randStim();
    stimT s;
    s.lu  = ($urandom_range(0, 3) == 0);
    s.bu  = ($urandom_range(0, 5) == 0);
    s.lh  = ($urandom_range(0, 1) == 0);
    s.bt  = ($urandom_range(0, 3) == 0);
    s.jp  = ($urandom_range(0, 7) == 0);
    s.req = ($urandom_range(0, 3) == 0);
    s.rdy = ($urandom_range(0, 1) == 0);
    s.clr = ($urandom_range(0, 31) == 0);
    return s;
  endfunction

  // Monitor: outputs are valid every cycle; sample mid-cycle
  initial begin
    expT e, got;
    forever begin
      @(negedge clk);
      if (expQ.size() != 0) begin
        e   = expQ.pop_front();
        got = {pcWrite_o, ifidWrite_o, ifidFlush_o, idexBubble_o, pipeHold_o,
               loadStallFlag_o, memTimeout_o, state_o, stallCount_o};
        compared++;
        if (got !== e) begin
          mismatched++;
          $display("FAIL outputs t=%0t got pc=%b ifw=%b fl=%b bub=%b hold=%b lsf=%b mt=%b st=%0d sc=%0d required pc=%b ifw=%b fl=%b bub=%b hold=%b lsf=%b mt=%b st=%0d sc=%0d",
                   $time, got.pcW, got.ifW, got.fl, got.bub, got.hold, got.lsf, got.mt, got.st, got.sc,
                   e.pcW, e.ifW, e.fl, e.bub, e.hold, e.lsf, e.mt, e.st, e.sc);
        end
      end
    end
  end

  initial begin
    stimT z, s;
    z = '0;
    rst_n = 1'b0;
    {loadUseEX_i, branchUseID_i, loadHazard_i, branchTakenID_i} = '0;
    {jumpID_i, dmemReq_i, dmemReady_i, clearStats_i} = '0;

    // Reset with random inputs, then release with quiet inputs
    repeat (3) step(1'b0, randStim());
    repeat (2) step(1'b1, z);

    // Load-use followed by a bypass hazard: two stalls via phase 2
    s = z; s.lu = 1'b1; step(1'b1, s);
    s = z; s.lh = 1'b1; step(1'b1, s);
    step(1'b1, z);

    // Branch-use beats load-use: 0 -> 1 -> 2 -> 0, no stall in the last phase
    s = z; s.bu = 1'b1; s.lu = 1'b1; step(1'b1, s);
    step(1'b1, z);
    step(1'b1, z);
    step(1'b1, z);

    // Memory hold in the middle of a branch-use interlock
    s = z; s.bu = 1'b1; step(1'b1, s);
    s = z; s.req = 1'b1; repeat (3) step(1'b1, s);
    repeat (3) step(1'b1, z);

    // Flush on taken branch / jump, suppressed by a load-use stall
    s = z; s.bt = 1'b1; step(1'b1, s);
    s = z; s.jp = 1'b1; step(1'b1, s);
    s = z; s.bt = 1'b1; s.lu = 1'b1; step(1'b1, s);
    repeat (2) step(1'b1, z);

    // Reset abandons an interlock in progress
    s = z; s.bu = 1'b1; step(1'b1, s);
    step(1'b0, z);
    repeat (2) step(1'b1, z);

    // Hold run of 254 does not time out; 255 does; sticky until cleared
    s = z; s.req = 1'b1; repeat (254) step(1'b1, s);
    step(1'b1, z);
    s = z; s.req = 1'b1; s.rdy = 1'b0; repeat (258) step(1'b1, s);
    s = z; s.req = 1'b1; s.rdy = 1'b1; step(1'b1, s);
    step(1'b1, z);
    s = z; s.clr = 1'b1; step(1'b1, s);
    repeat (2) step(1'b1, z);

    // Randomized traffic with occasional resets
    repeat (3000) step(($urandom_range(0, 99) != 0), randStim());
    step(1'b0, z);
    step(1'b1, z);

    // Stall every cycle long enough to saturate the statistics counter
    s = z; s.lu = 1'b1; s.lh = 1'b1; repeat (65600) step(1'b1, s);
    s = z; s.clr = 1'b1; step(1'b1, s);
    repeat (2) step(1'b1, z);

    repeat (3) @(posedge clk);
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
